// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM stage bus controller with stall, timeout and MEM/WB register
module mem_stage_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int TO_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  MEMrd,
  input  logic [31:0] MEMPC,
  input  logic [31:0] MEMALUOut,
  input  logic [31:0] MEMDatabus3,
  input  logic        MEMRegWrite,
  input  logic        MEMMemRead,
  input  logic        MEMMemWrite,
  input  logic [1:0]  MEMMemtoReg,
  output logic        mem_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        misalign,
  output logic        bus_err,
  output logic [4:0]  WBrd,
  output logic        WBRegWrite,
  output logic [31:0] WBData
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [TO_W-1:0] cnt;
  logic op, mis, start, done, abort, wb_load;
  logic [31:0] wb_data;
  assign op = MEMMemRead | MEMMemWrite;
  assign mis = op & (|MEMALUOut[1:0]);
  assign start = (state == IDLE) & op & ~mis;
  assign done = (state == BUSY) & bus_ack;
  // ack takes priority over a coincident timeout
  assign abort = (state == BUSY) & ~bus_ack & (cnt == TO_W'(TIMEOUT - 1));
  assign mem_stall = start | ((state == BUSY) & ~done & ~abort);
  assign wb_load = ((state == IDLE) & ~op) | done;
  assign wb_data = (MEMMemtoReg == 2'b01) ? bus_rdata :
                   (MEMMemtoReg == 2'b10) ? MEMPC + 32'd4 : MEMALUOut;
  always_comb begin
    state_n = state;
    if (start) state_n = BUSY;
    else if (done | abort) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      misalign   <= 1'b0;
      bus_err    <= 1'b0;
      WBrd       <= '0;
      WBRegWrite <= 1'b0;
      WBData     <= '0;
    end else begin
      state    <= state_n;
      misalign <= (state == IDLE) & mis;
      bus_err  <= abort;
      if (start) begin
        bus_req   <= 1'b1;
        bus_we    <= MEMMemWrite & ~MEMMemRead;
        bus_addr  <= {MEMALUOut[31:2], 2'b00};
        bus_wdata <= MEMDatabus3;
        cnt       <= '0;
      end else if (done | abort) begin
        bus_req <= 1'b0;
      end else if (state == BUSY) begin
        cnt <= cnt + TO_W'(1);
      end
      WBrd       <= wb_load ? MEMrd : 5'd0;
      WBRegWrite <= wb_load & MEMRegWrite;
      WBData     <= wb_load ? wb_data : 32'd0;
    end
  end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: scoreboard bench for the memory-stage controller
module tb_mem_stage_ctrl;
  localparam int TIMEOUT = 15;
  logic        clk, reset;
  logic [4:0]  MEMrd;
  logic [31:0] MEMPC, MEMALUOut, MEMDatabus3;
  logic        MEMRegWrite, MEMMemRead, MEMMemWrite;
  logic [1:0]  MEMMemtoReg;
  logic        mem_stall, bus_req, bus_we, bus_ack, misalign, bus_err, WBRegWrite;
  logic [31:0] bus_addr, bus_wdata, bus_rdata, WBData;
  logic [4:0]  WBrd;
  typedef struct packed {logic [4:0] rd; logic [31:0] data;} wb_t;
  wb_t exp_q[$];
  int passed = 0, total = 0;

  mem_stage_ctrl #(.TIMEOUT(TIMEOUT), .TO_W(4)) dut (
    .clk(clk), .reset(reset), .MEMrd(MEMrd), .MEMPC(MEMPC), .MEMALUOut(MEMALUOut),
    .MEMDatabus3(MEMDatabus3), .MEMRegWrite(MEMRegWrite), .MEMMemRead(MEMMemRead),
    .MEMMemWrite(MEMMemWrite), .MEMMemtoReg(MEMMemtoReg), .mem_stall(mem_stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .misalign(misalign), .bus_err(bus_err),
    .WBrd(WBrd), .WBRegWrite(WBRegWrite), .WBData(WBData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // every write-back must match the oldest expected write, and none may appear unexpected
  always @(negedge clk) begin
    wb_t e;
    if (!reset && WBRegWrite) begin
      total++;
      if (exp_q.size() == 0) $display("FAIL wb_unexpected: got rd=%0d data=%h, expected no write", WBrd, WBData);
      else begin
        e = exp_q.pop_front();
        if ({WBrd, WBData} !== {e.rd, e.data}) $display("FAIL wb_data: got rd=%0d data=%h, expected rd=%0d data=%h", WBrd, WBData, e.rd, e.data);
        else passed++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rd, input logic [31:0] pc, alu, wd,
                       input logic rw, mr, mw, input logic [1:0] mtr);
    MEMrd = rd; MEMPC = pc; MEMALUOut = alu; MEMDatabus3 = wd;
    MEMRegWrite = rw; MEMMemRead = mr; MEMMemWrite = mw; MEMMemtoReg = mtr;
  endtask

  // presents one memory instruction, holds it while stalled, acks in BUSY cycle ack_at (0 = never)
  task automatic run_access(input logic [4:0] rd, input logic [31:0] addr, wdata,
                            input logic rw, mr, mw, input logic [1:0] mtr,
                            input int ack_at, input logic [31:0] rdata,
                            output int stalls, reqs, output logic err, mis, req_after, we,
                            output logic [31:0] a, wd);
    int cyc;
    bit fin;
    tick();
    drive(rd, 32'h1000, addr, wdata, rw, mr, mw, mtr);
    stalls = 0; reqs = 0; we = 0; a = 0; wd = 0; cyc = 0; fin = 0;
    while (!fin && cyc < 40) begin
      if (cyc > 0) begin
        tick();
        bus_ack = (cyc == ack_at);
        bus_rdata = rdata;
      end
      @(negedge clk);
      if (mem_stall) stalls++;
      if (bus_req) begin reqs++; we = bus_we; a = bus_addr; wd = bus_wdata; end
      fin = !mem_stall;
      cyc++;
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    bus_ack = 0;
    @(negedge clk);
    err = bus_err; mis = misalign; req_after = bus_req;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    bus_ack = 0; bus_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (bus_req !== 1'b0) $display("FAIL rst_req: got %b want 0", bus_req); else passed++;
    total++; if ({bus_we, bus_addr, bus_wdata} !== 65'd0) $display("FAIL rst_bus: got we=%b addr=%h wdata=%h want 0", bus_we, bus_addr, bus_wdata); else passed++;
    total++; if ({misalign, bus_err} !== 2'b00) $display("FAIL rst_pulses: got mis=%b err=%b want 0", misalign, bus_err); else passed++;
    total++; if ({WBrd, WBRegWrite, WBData} !== 38'd0) $display("FAIL rst_wb: got rd=%0d rw=%b data=%h want 0", WBrd, WBRegWrite, WBData); else passed++;
    total++; if (mem_stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", mem_stall); else passed++;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_alu();
    tick();
    drive(5'd5, 32'h2000, 32'h1234, 32'hFFFF, 1, 0, 0, 2'b00);
    exp_q.push_back('{5'd5, 32'h1234});
    @(negedge clk);
    total++; if (mem_stall !== 1'b0) $display("FAIL alu_stall: got %b want 0", mem_stall); else passed++;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++; if (WBRegWrite !== 1'b1) $display("FAIL alu_wb_latency: got rw=%b want 1", WBRegWrite); else passed++;
    total++; if (bus_req !== 1'b0) $display("FAIL alu_no_req: got %b want 0", bus_req); else passed++;
  endtask

  task automatic test_link();
    tick();
    drive(5'd31, 32'hFFFFFFFC, 32'h5555, 0, 1, 0, 0, 2'b10);
    exp_q.push_back('{5'd31, 32'h0});
    tick();
    drive(5'd3, 32'h10, 32'h77, 0, 1, 0, 0, 2'b11);
    exp_q.push_back('{5'd3, 32'h77});
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++; if (WBData !== 32'h77) $display("FAIL sel11_data: got %h want 00000077", WBData); else passed++;
  endtask

  task automatic test_load();
    int s, r;
    logic e, m, ra, w;
    logic [31:0] a, wd;
    exp_q.push_back('{5'd7, 32'hDEADBEEF});
    run_access(5'd7, 32'h40, 32'h0, 1, 1, 0, 2'b01, 3, 32'hDEADBEEF, s, r, e, m, ra, w, a, wd);
    total++; if (s !== 3) $display("FAIL load_stall: got %0d cycles want 3", s); else passed++;
    total++; if (r !== 3) $display("FAIL load_req: got %0d cycles want 3", r); else passed++;
    total++; if ({w, a} !== {1'b0, 32'h40}) $display("FAIL load_bus: got we=%b addr=%h want we=0 addr=00000040", w, a); else passed++;
    total++; if ({e, ra} !== 2'b00) $display("FAIL load_end: got err=%b req=%b want 0 0", e, ra); else passed++;
  endtask

  task automatic test_store();
    int s, r;
    logic e, m, ra, w;
    logic [31:0] a, wd;
    run_access(5'd0, 32'h80, 32'hA5A5A5A5, 0, 0, 1, 2'b00, 1, 32'h0, s, r, e, m, ra, w, a, wd);
    total++; if (s !== 1) $display("FAIL store_stall: got %0d want 1", s); else passed++;
    total++; if ({w, a, wd} !== {1'b1, 32'h80, 32'hA5A5A5A5}) $display("FAIL store_bus: got we=%b addr=%h wdata=%h want 1 00000080 a5a5a5a5", w, a, wd); else passed++;
    total++; if (WBRegWrite !== 1'b0) $display("FAIL store_wb: got rw=%b want 0", WBRegWrite); else passed++;
  endtask

  task automatic test_rd_and_wr();
    int s, r;
    logic e, m, ra, w;
    logic [31:0] a, wd;
    exp_q.push_back('{5'd9, 32'h11223344});
    run_access(5'd9, 32'h84, 32'h99, 1, 1, 1, 2'b01, 2, 32'h11223344, s, r, e, m, ra, w, a, wd);
    total++; if ({s, w} !== {32'd2, 1'b0}) $display("FAIL rdwr: got stall=%0d we=%b want 2 0", s, w); else passed++;
  endtask

  task automatic test_misalign();
    int s, r;
    logic e, m, ra, w;
    logic [31:0] a, wd;
    run_access(5'd8, 32'h42, 32'h0, 1, 1, 0, 2'b01, 1, 32'h12345678, s, r, e, m, ra, w, a, wd);
    total++; if ({s, r} !== 64'd0) $display("FAIL mis_nobus: got stall=%0d req=%0d want 0 0", s, r); else passed++;
    total++; if ({m, e, ra} !== 3'b100) $display("FAIL mis_pulse: got mis=%b err=%b req=%b want 1 0 0", m, e, ra); else passed++;
    @(negedge clk);
    total++; if (misalign !== 1'b0) $display("FAIL mis_one_cycle: got %b want 0", misalign); else passed++;
  endtask

  task automatic test_timeout();
    int s, r;
    logic e, m, ra, w;
    logic [31:0] a, wd;
    run_access(5'd10, 32'h44, 32'h0, 1, 1, 0, 2'b01, 0, 32'hBAD0BAD0, s, r, e, m, ra, w, a, wd);
    total++; if (r !== TIMEOUT) $display("FAIL to_req: got %0d cycles want %0d", r, TIMEOUT); else passed++;
    total++; if (s !== TIMEOUT) $display("FAIL to_stall: got %0d cycles want %0d", s, TIMEOUT); else passed++;
    total++; if ({e, ra} !== 2'b10) $display("FAIL to_err: got err=%b req=%b want 1 0", e, ra); else passed++;
    @(negedge clk);
    total++; if (bus_err !== 1'b0) $display("FAIL to_err_pulse: got %b want 0", bus_err); else passed++;
    exp_q.push_back('{5'd11, 32'hCAFEF00D});
    run_access(5'd11, 32'h48, 32'h0, 1, 1, 0, 2'b01, TIMEOUT, 32'hCAFEF00D, s, r, e, m, ra, w, a, wd);
    total++; if ({r, s} !== {TIMEOUT, TIMEOUT}) $display("FAIL ack_last: got req=%0d stall=%0d want %0d", r, s, TIMEOUT); else passed++;
    total++; if (e !== 1'b0) $display("FAIL ack_last_err: got %b want 0", e); else passed++;
  endtask

  task automatic test_idle_ack();
    tick();
    bus_ack = 1; bus_rdata = 32'h0BADF00D;
    @(negedge clk);
    total++; if (mem_stall !== 1'b0) $display("FAIL idle_ack_stall: got %b want 0", mem_stall); else passed++;
    tick();
    bus_ack = 0;
    @(negedge clk);
    total++; if ({bus_req, WBRegWrite, bus_err} !== 3'b000) $display("FAIL idle_ack: got req=%b rw=%b err=%b want 0", bus_req, WBRegWrite, bus_err); else passed++;
  endtask

  task automatic test_reset_busy();
    tick();
    drive(5'd12, 32'h0, 32'h100, 32'h0, 1, 1, 0, 2'b01);
    tick();
    tick();
    #2;
    total++; if (bus_req !== 1'b1) $display("FAIL rb_pre: got req=%b want 1", bus_req); else passed++;
    reset = 1'b1;
    #1;
    total++; if ({bus_req, bus_we, bus_addr, bus_err, WBRegWrite, WBData} !== 67'd0) $display("FAIL rb_async: got req=%b addr=%h err=%b rw=%b want 0", bus_req, bus_addr, bus_err, WBRegWrite); else passed++;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    total++; if ({bus_req, bus_err, mem_stall} !== 3'b000) $display("FAIL rb_after: got req=%b err=%b stall=%b want 0", bus_req, bus_err, mem_stall); else passed++;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_link();
    test_load();
    test_store();
    test_rd_and_wr();
    test_misalign();
    test_timeout();
    test_idle_ack();
    test_reset_busy();
    repeat (2) tick();
    total++; if (exp_q.size() != 0) $display("FAIL wb_missing: got %0d pending writes want 0", exp_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
